// File: rtl/rs485_uart_rx.sv
// ---------------------------------------------------------------------------
// rs485_uart_rx
//   8N1 UART receiver for the RS485 transceiver RO pin. The line is
//   synchronised, oversampled with a baud counter and each bit is sampled at
//   mid-period. The last correctly framed byte is held on rx_out_data for the
//   display path downstream; rx_done / rx_err are single-cycle strobes.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   UART_BPS     baud rate in bit/s
//
// Ports
//   sys_clk      in   1  system clock, rising edge
//   sys_rst_n    in   1  synchronous active-low reset
//   rs485_rx     in   1  asynchronous serial input, idle high
//   rx_out_data  out  8  last good byte (LSB received first)
//   rx_done      out  1  strobe: rx_out_data updated this cycle
//   rx_err       out  1  strobe: stop bit sampled low (framing error)
//   rx_busy      out  1  high while a frame is being received
// ---------------------------------------------------------------------------
module rs485_uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rs485_rx,
    output logic [7:0] rx_out_data,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);

    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Too few clocks per bit leaves no room for mid-bit sampling.
    generate
        if (BPS_CNT < 16) begin : g_bps_check
            $error("rs485_uart_rx: CLK_FREQ/UART_BPS must be at least 16");
        end
    endgenerate

    logic          rx_s0;
    logic          rx_s1;
    logic          rx_s2;
    logic          fall;
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          at_half;
    logic          at_last;

    // Synchroniser plus one delay stage for edge detection. Reset to the idle
    // level so that releasing reset never looks like a start edge on an idle line.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_s0 <= 1'b1;
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s0 <= rs485_rx;
            rx_s1 <= rx_s0;
            rx_s2 <= rx_s1;
        end
    end

    assign fall    = rx_s2 & ~rx_s1;
    assign at_half = (baud_cnt == CNT_HALF);
    assign at_last = (baud_cnt == CNT_LAST);
    assign rx_busy = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx_out_data <= 8'h00;
            rx_done     <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    // A start bit that is high again by mid-bit was only a glitch.
                    if (at_half && rx_s1) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                    end else if (at_last) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_half) begin
                        shift[bit_idx] <= rx_s1;
                    end
                    if (at_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start edge in the second half of
                    // the stop bit is still seen.
                    if (at_half) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        if (rx_s1) begin
                            rx_out_data <= shift;
                            rx_done     <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs485_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_rs485_uart_rx
//   Self-checking bench for rs485_uart_rx at default parameters. Frames are
//   serialised bit by bit onto rs485_rx; a monitor collects strobes and the
//   expected bytes/errors come from the frame contents themselves.
// ---------------------------------------------------------------------------
module tb_rs485_uart_rx;

    localparam int BPS  = 50_000_000 / 115200;   // 434
    localparam int HALF = BPS / 2;               // 217

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_out_data;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    rs485_uart_rx #(
        .CLK_FREQ(50_000_000),
        .UART_BPS(115200)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .rs485_rx   (rx),
        .rx_out_data(rx_out_data),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_busy    (rx_busy)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------ monitor
    int         cyc = 0;
    logic       rst_sampled = 1'b0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         overlap_cnt = 0;
    int         long_cnt = 0;
    int         bad_chg_cnt = 0;
    int         last_done_cyc = 0;
    int         busy_run = 0;
    int         last_busy_run = 0;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] done_q[$];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_sampled <= rst_n;
    end

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            done_q.push_back(rx_out_data);
            last_done_cyc <= cyc;
        end
        if (rx_err === 1'b1) err_cnt <= err_cnt + 1;
        if (rx_done === 1'b1 && rx_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
        if ((rx_done === 1'b1 && prev_done) || (rx_err === 1'b1 && prev_err))
            long_cnt <= long_cnt + 1;
        if (rx_out_data !== prev_data && rx_done !== 1'b1 && rst_sampled === 1'b1)
            bad_chg_cnt <= bad_chg_cnt + 1;
        if (rx_busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            last_busy_run <= busy_run;
            busy_run      <= 0;
        end
        prev_done <= (rx_done === 1'b1);
        prev_err  <= (rx_err === 1'b1);
        prev_data <= rx_out_data;
    end

    // ------------------------------------------------------------------ model
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    int         exp_err = 0;
    logic [7:0] exp_data = 8'h00;

    // A frame is accepted exactly when its stop bit is high.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_q.push_back(d);
            exp_done++;
            exp_data = d;
        end else begin
            exp_err++;
        end
    endtask

    // ------------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_cycles);
        rx = 1'b0;
        tick(BPS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BPS);
        end
        rx = stop;
        tick(stop_cycles);
        rx = 1'b1;
    endtask

    // Bounded wait for the monitor to have seen the expected number of strobes.
    task automatic wait_strobes(input string tag, input int budget);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) < (exp_done + exp_err) && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        chk(tag, done_cnt + err_cnt, exp_done + exp_err);
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] got;
        logic [7:0] want;
        while (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = (done_q.size() != 0) ? done_q.pop_front() : 8'hxx;
            chk(tag, got, want);
        end
        chk({tag, "_extra"}, done_q.size(), 0);
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        int t0;
        int lat;
        logic [7:0] d;
        logic stop;
        int gap;

        // 1. reset and idle
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        chk("rst_data", rx_out_data, 8'h00);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_err", rx_err, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        tick(2000);
        chk("idle_done", done_cnt, 0);
        chk("idle_err", err_cnt, 0);

        // 2. single frame with latency
        t0 = cyc;
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, BPS);
        wait_strobes("a5_strobe", 2 * BPS);
        lat = last_done_cyc - t0;
        chk("a5_latency", (lat >= 9 * BPS + HALF + 3 && lat <= 9 * BPS + HALF + 5), 1'b1);
        $display("frame a5 latency=%0d data=%0h", lat, rx_out_data);
        chk("a5_data", rx_out_data, exp_data);
        chk("a5_busy", rx_busy, 1'b0);
        check_bytes("a5_q");

        // 3. back-to-back with no idle gap
        model_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1, BPS);
        model_frame(8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1, BPS);
        wait_strobes("b2b_strobe", 2 * BPS);
        $display("back-to-back done=%0d data=%0h", done_cnt, rx_out_data);
        check_bytes("b2b_q");
        chk("b2b_err", err_cnt, exp_err);

        // 4. glitch shorter than half a bit
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(3 * BPS);
        $display("glitch busy_run=%0d", last_busy_run);
        chk("glitch_busy_run", last_busy_run, HALF + 1);
        chk("glitch_strobes", done_cnt + err_cnt, exp_done + exp_err);
        chk("glitch_data", rx_out_data, 8'hFF);

        // 5. framing error, then a clean frame after two idle bits
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, BPS);
        wait_strobes("ferr_strobe", 2 * BPS);
        $display("framing err_cnt=%0d data=%0h", err_cnt, rx_out_data);
        chk("ferr_err", err_cnt, exp_err);
        chk("ferr_done", done_cnt, exp_done);
        chk("ferr_data", rx_out_data, 8'hFF);
        tick(2 * BPS);
        model_frame(8'h12, 1'b1);
        send_frame(8'h12, 1'b1, BPS);
        wait_strobes("f12_strobe", 2 * BPS);
        $display("frame 12 data=%0h", rx_out_data);
        chk("f12_data", rx_out_data, exp_data);
        check_bytes("f12_q");

        // 6. reset during data bit 3 of 0x77; the sender is reset too and idles
        d  = 8'h77;
        rx = 1'b0;
        tick(BPS);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            tick(BPS);
        end
        rx = d[3];
        tick(100);
        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        exp_data = 8'h00;
        chk("mrst_data", rx_out_data, 8'h00);
        chk("mrst_busy", rx_busy, 1'b0);
        tick(12 * BPS);
        chk("mrst_strobes", done_cnt + err_cnt, exp_done + exp_err);
        $display("mid-frame reset data=%0h busy=%0b", rx_out_data, rx_busy);
        tick(2 * BPS);
        model_frame(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1, BPS);
        wait_strobes("f5a_strobe", 2 * BPS);
        $display("frame 5a data=%0h", rx_out_data);
        chk("f5a_data", rx_out_data, exp_data);
        check_bytes("f5a_q");

        // 7. randomized frames
        for (int k = 0; k < 4; k++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            // After a low stop bit the line must return high before a new start edge.
            gap  = stop ? $urandom_range(0, 2 * BPS) : $urandom_range(BPS, 2 * BPS);
            model_frame(d, stop);
            send_frame(d, stop, BPS);
            wait_strobes("rnd_strobe", 2 * BPS);
            $display("random frame %0d byte=%0h stop=%0b data=%0h", k, d, stop, rx_out_data);
            chk("rnd_data", rx_out_data, exp_data);
            tick(gap);
        end
        check_bytes("rnd_q");
        chk("rnd_err", err_cnt, exp_err);

        // global strobe properties
        chk("overlap", overlap_cnt, 0);
        chk("strobe_len", long_cnt, 0);
        chk("data_hold", bad_chg_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
